// File: rtl/mips_alu_muldiv.sv
// rtl/mips_alu_muldiv.sv - multicycle multiply/divide unit owning the HI/LO registers
// One shift-add or restoring-divide step per cycle; signs are stripped on entry and restored in FIX.
module mips_alu_muldiv #(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] reg_lo,
    output logic [DATA_W-1:0] reg_hi
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opnd;
    logic [DATA_W-1:0]     r_rem;
    logic                  r_is_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div0;
    logic                  r_done;
    logic [DATA_W-1:0]     r_lo;
    logic [DATA_W-1:0]     r_hi;

    logic                  w_accept;
    logic                  w_md_start;
    logic                  w_sign1;
    logic                  w_sign2;
    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W:0]       w_mul_sum;
    logic [2*DATA_W-1:0]   w_mul_next;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W-1:0]     w_diff;
    logic                  w_div_ge;
    logic [DATA_W-1:0]     w_rem_next;
    logic [2*DATA_W-1:0]   w_prod_fix;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_md_start = w_accept && !op[2];
    assign w_sign1    = op[0] & data1[DATA_W-1];
    assign w_sign2    = op[0] & data2[DATA_W-1];
    assign w_abs1     = w_sign1 ? -data1 : data1;
    assign w_abs2     = w_sign2 ? -data2 : data2;

    // Multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // w_shift is the DATA_W+1 bit partial remainder; a set top bit already exceeds any divisor.
    assign w_shift    = {r_rem, r_acc[DATA_W-1]};
    assign w_diff     = w_shift[DATA_W-1:0] - r_opnd;
    assign w_div_ge   = w_shift[DATA_W] || (w_shift[DATA_W-1:0] >= r_opnd);
    assign w_rem_next = w_div_ge ? w_diff : w_shift[DATA_W-1:0];

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_md_start) w_next = S_RUN;
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_rem    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            r_done <= (r_state == S_FIX) && !flush;
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_sign1 ^ w_sign2;
                        r_neg_r  <= w_sign1;
                        r_div0   <= (data2 == '0);
                        r_cnt    <= CNT_W'(DATA_W);
                        r_rem    <= '0;
                        r_opnd   <= op[1] ? w_abs2 : w_abs1;
                        r_acc    <= {{DATA_W{1'b0}}, (op[1] ? w_abs1 : w_abs2)};
                    end else if (w_accept && op == 3'd4) begin
                        r_lo <= data1;
                    end else if (w_accept && op == 3'd5) begin
                        r_hi <= data1;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_is_div) begin
                            r_rem               <= w_rem_next;
                            r_acc[DATA_W-1:0]   <= {r_acc[DATA_W-2:0], w_div_ge};
                        end else begin
                            r_acc <= w_mul_next;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_lo <= w_prod_fix[DATA_W-1:0];
                            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign reg_lo = r_lo;
    assign reg_hi = r_hi;

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// tb/tb_mips_alu_muldiv.sv - directed vectors with a done-driven scoreboard monitor
module tb_mips_alu_muldiv;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] reg_lo;
    logic [31:0] reg_hi;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int nbusy;

    mips_alu_muldiv #(.DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .data1 (data1),
        .data2 (data2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .reg_lo(reg_lo),
        .reg_hi(reg_hi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (hi=%h lo=%h)", reg_hi, reg_lo);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("result_hilo", {reg_hi, reg_lo}, e);
                check("busy_low_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] e);
        int n;
        wait_idle(n);
        if (push) begin
            sb.push_back(e);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        start = 1'b1;
        op    = o;
        data1 = a;
        data2 = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e);
        int n;
        issue(o, a, b, 1'b1, e);
        wait_idle(n);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; data1 = '0; data2 = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {reg_hi, reg_lo}, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // MTLO, then reset in the middle of a MULU
        issue(3'd4, 32'h0000_0055, 32'h0, 1'b0, 64'd0);
        check("mtlo_lo", {32'd0, reg_lo}, 64'h55);
        issue(3'd0, 32'd7, 32'd9, 1'b0, 64'd0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", {63'd0, busy}, 64'd0);
        check("midrun_reset_hilo", {reg_hi, reg_lo}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;

        // Latency and back-to-back acceptance in the done cycle
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_idle(nbusy);
        check("mulu_busy_cycles", 64'(nbusy), 64'd33);
        check("mulu_done_at_T34", {63'd0, done}, 64'd1);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5,        {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
        run_op(3'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFA, {32'h0000_0000, 32'h0000_0018});
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd3, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        run_op(3'd2, 32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E});
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        run_op(3'd2, 32'd5,         32'd0,        {32'h0000_0005, 32'hFFFF_FFFF});
        run_op(3'd3, 32'hFFFF_FFFB, 32'd0,        {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // MTLO while busy must be dropped
        issue(3'd0, 32'd7, 32'd9, 1'b1, {32'h0, 32'd63});
        start = 1'b1; op = 3'd4; data1 = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("mtlo_busy_ignored", {32'd0, reg_lo}, {32'd0, 32'hFFFF_FFFF});
        wait_idle(nbusy);

        // MTHI in idle: HI only, no done
        issue(3'd5, 32'h0000_1234, 32'h0, 1'b0, 64'd0);
        m_hi = 32'h0000_1234;
        check("mthi_hilo", {reg_hi, reg_lo}, {32'h0000_1234, 32'd63});
        check("mthi_no_done", {63'd0, done}, 64'd0);

        // Flush a DIVU at T+10
        issue(3'd2, 32'd100, 32'd7, 1'b0, 64'd0);
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hilo", {reg_hi, reg_lo}, {m_hi, m_lo});
        repeat (40) @(posedge clock);
        #1;
        check("flush_hilo_later", {reg_hi, reg_lo}, {m_hi, m_lo});
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
